// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards ALU results in one cycle and runs
// load/store transactions on a req/ack data-memory port with timeout and alignment checks.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_st_data,
  input  logic [31:0] ex_pc,
  input  logic        ex_isLd,
  input  logic        ex_isSt,
  input  logic        ex_isCall,
  input  logic        ex_isWb,
  input  logic [3:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_ld_result,
  output logic [31:0] wb_pc,
  output logic        wb_isLd,
  output logic        wb_isCall,
  output logic        wb_isWb,
  output logic [3:0]  wb_rd,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt;
  logic [8:0]  cnt_inc;
  logic [31:0] alu_hold, pc_hold;
  logic [3:0]  rd_hold;
  logic        ld_hold, call_hold, wb_hold;
  logic        accept, is_mem, misaligned, timeout_hit;

  assign accept      = ex_valid && (state_reg == IDLE);
  assign is_mem      = ex_isLd || ex_isSt;
  assign misaligned  = |ex_alu_res[1:0];
  assign cnt_inc     = {1'b0, wait_cnt} + 9'd1;
  // Ack wins over a simultaneous timeout, so the timeout term excludes it.
  assign timeout_hit = !dmem_ack && (cnt_inc == 9'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ex_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        ex_ready = 1'b1;
        if (accept && is_mem) state_next = misaligned ? DONE : WAIT_ACK;
      end
      WAIT_ACK: if (dmem_ack || timeout_hit) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_alu_res   <= '0;
      wb_ld_result <= '0;
      wb_pc        <= '0;
      wb_isLd      <= 1'b0;
      wb_isCall    <= 1'b0;
      wb_isWb      <= 1'b0;
      wb_rd        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      wait_cnt     <= '0;
      alu_hold     <= '0;
      pc_hold      <= '0;
      rd_hold      <= '0;
      ld_hold      <= 1'b0;
      call_hold    <= 1'b0;
      wb_hold      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept && (!is_mem || misaligned)) begin
            // Immediate result: ALU op, or a rejected misaligned access.
            wb_valid     <= 1'b1;
            wb_alu_res   <= ex_alu_res;
            wb_pc        <= ex_pc;
            wb_rd        <= ex_rd;
            wb_isCall    <= ex_isCall;
            wb_isLd      <= 1'b0;
            wb_isWb      <= is_mem ? 1'b0 : ex_isWb;
            err_misalign <= is_mem;
          end else if (accept) begin
            // Fields are parked until completion so wb_* stay stable meanwhile.
            dmem_req   <= 1'b1;
            dmem_we    <= !ex_isLd;
            dmem_addr  <= ex_alu_res;
            dmem_wdata <= ex_st_data;
            wait_cnt   <= '0;
            alu_hold   <= ex_alu_res;
            pc_hold    <= ex_pc;
            rd_hold    <= ex_rd;
            ld_hold    <= ex_isLd;
            call_hold  <= ex_isCall;
            wb_hold    <= ex_isWb;
          end
        end
        WAIT_ACK: begin
          if (dmem_ack || timeout_hit) begin
            dmem_req   <= 1'b0;
            wb_valid   <= 1'b1;
            wb_alu_res <= alu_hold;
            wb_pc      <= pc_hold;
            wb_rd      <= rd_hold;
            wb_isCall  <= call_hold;
            if (dmem_ack) begin
              wb_isLd <= ld_hold;
              wb_isWb <= wb_hold;
              if (ld_hold) wb_ld_result <= dmem_rdata;
            end else begin
              wb_isLd      <= 1'b0;
              wb_isWb      <= 1'b0;
              wb_ld_result <= '0;
              err_timeout  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load, store, misalign,
// timeout, ack/timeout race, stray ack and reset during an access.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_res, ex_st_data, ex_pc;
  logic        ex_isLd, ex_isSt, ex_isCall, ex_isWb;
  logic [3:0]  ex_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_alu_res, wb_ld_result, wb_pc;
  logic        wb_isLd, wb_isCall, wb_isWb;
  logic [3:0]  wb_rd;
  logic        err_misalign, err_timeout;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_res(ex_alu_res), .ex_st_data(ex_st_data), .ex_pc(ex_pc),
    .ex_isLd(ex_isLd), .ex_isSt(ex_isSt), .ex_isCall(ex_isCall), .ex_isWb(ex_isWb),
    .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_ld_result(wb_ld_result), .wb_pc(wb_pc),
    .wb_isLd(wb_isLd), .wb_isCall(wb_isCall), .wb_isWb(wb_isWb), .wb_rd(wb_rd),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic ld,
                       input logic st, input logic wb, input logic [3:0] rd);
    ex_valid = 1'b1; ex_alu_res = alu; ex_st_data = sd; ex_isLd = ld; ex_isSt = st;
    ex_isWb = wb; ex_rd = rd; ex_pc = alu + 32'h1000; ex_isCall = 1'b0;
    tick();
    ex_valid = 1'b0;
    $display("txn alu=%h ld=%0d st=%0d rd=%0d", alu, ld, st, rd);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_alu_res = 0; ex_st_data = 0; ex_pc = 0;
    ex_isLd = 0; ex_isSt = 0; ex_isCall = 0; ex_isWb = 0; ex_rd = 0;
    dmem_rdata = 0; dmem_ack = 0;
    tick(); tick();
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_alu", wb_alu_res, 32'h0);
    chk("rst_rd", 32'(wb_rd), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op
    issue(32'h1234, 32'h0, 0, 0, 1, 4'd3);
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_res", wb_alu_res, 32'h1234);
    chk("alu_rd", 32'(wb_rd), 32'd3);
    chk("alu_iswb", 32'(wb_isWb), 32'd1);
    chk("alu_isld", 32'(wb_isLd), 32'd0);
    chk("alu_pc", wb_pc, 32'h2234);
    chk("alu_ready", 32'(ex_ready), 32'd1);
    tick();
    chk("alu_pulse_end", 32'(wb_valid), 32'd0);
    chk("alu_hold", wb_alu_res, 32'h1234);

    // Load with ack two cycles after request
    issue(32'h100, 32'h0, 1, 0, 1, 4'd5);
    chk("ld_req", 32'(dmem_req), 32'd1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_ready_low", 32'(ex_ready), 32'd0);
    tick();
    chk("ld_wait_req", 32'(dmem_req), 32'd1);
    chk("ld_wait_valid", 32'(wb_valid), 32'd0);
    chk("ld_wait_hold_alu", wb_alu_res, 32'h1234);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    chk("ld_valid", 32'(wb_valid), 32'd1);
    chk("ld_result", wb_ld_result, 32'hCAFEF00D);
    chk("ld_isld", 32'(wb_isLd), 32'd1);
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    chk("ld_rd", 32'(wb_rd), 32'd5);
    chk("ld_done_ready", 32'(ex_ready), 32'd0);
    tick();
    chk("ld_idle_ready", 32'(ex_ready), 32'd1);
    chk("ld_pulse_end", 32'(wb_valid), 32'd0);

    // Store
    issue(32'h200, 32'h55AA55AA, 0, 1, 0, 4'd0);
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_wdata", dmem_wdata, 32'h55AA55AA);
    chk("st_addr", dmem_addr, 32'h200);
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    tick();
    dmem_ack = 1'b0;
    chk("st_valid", 32'(wb_valid), 32'd1);
    chk("st_iswb", 32'(wb_isWb), 32'd0);
    chk("st_isld", 32'(wb_isLd), 32'd0);
    chk("st_ldres_kept", wb_ld_result, 32'hCAFEF00D);
    tick();

    // Misaligned load
    issue(32'h102, 32'h0, 1, 0, 1, 4'd7);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_valid", 32'(wb_valid), 32'd1);
    chk("mis_err", 32'(err_misalign), 32'd1);
    chk("mis_iswb", 32'(wb_isWb), 32'd0);
    chk("mis_ready", 32'(ex_ready), 32'd0);
    tick();
    chk("mis_err_end", 32'(err_misalign), 32'd0);
    chk("mis_back_idle", 32'(ex_ready), 32'd1);

    // Timeout: no ack for 4 wait cycles
    issue(32'h300, 32'h0, 1, 0, 1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      chk("to_req_held", 32'(dmem_req), 32'd1);
      tick();
    end
    chk("to_req_4th", 32'(dmem_req), 32'd1);
    tick();
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_valid", 32'(wb_valid), 32'd1);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_ldres", wb_ld_result, 32'h0);
    chk("to_iswb", 32'(wb_isWb), 32'd0);
    tick();
    chk("to_err_end", 32'(err_timeout), 32'd0);

    // Ack in the 4th wait cycle wins over timeout
    issue(32'h304, 32'h0, 1, 0, 1, 4'd4);
    tick(); tick(); tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0;
    chk("race_valid", 32'(wb_valid), 32'd1);
    chk("race_err", 32'(err_timeout), 32'd0);
    chk("race_ldres", wb_ld_result, 32'hDEADBEEF);
    chk("race_iswb", 32'(wb_isWb), 32'd1);
    tick();

    // Stray ack while idle
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("stray_valid", 32'(wb_valid), 32'd0);
    chk("stray_ldres", wb_ld_result, 32'hDEADBEEF);

    // Reset during WAIT_ACK
    issue(32'h400, 32'h0, 1, 0, 1, 4'd6);
    chk("rw_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_drop", 32'(dmem_req), 32'd0);
    chk("rw_ready", 32'(ex_ready), 32'd1);
    chk("rw_alu_clr", wb_alu_res, 32'h0);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    chk("rw_late_ack_valid", 32'(wb_valid), 32'd0);
    chk("rw_late_ack_ldres", wb_ld_result, 32'h0);
    issue(32'h77, 32'h0, 0, 0, 1, 4'd2);
    chk("rw_alu_valid", 32'(wb_valid), 32'd1);
    chk("rw_alu_res", wb_alu_res, 32'h77);
    chk("rw_alu_rd", 32'(wb_rd), 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
